// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with an internal baud generator, a TX holding register
// with a valid/ready handshake, and an RX FIFO that keeps per-word error flags.
// Each bit lasts OVERSAMPLE ticks. One tick is baud_div+1 clk cycles.
module uart_fifo_core #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    input  logic             rx_in,
    output logic [7:0]       rx_data,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_overrun,
    input  logic             overrun_clr
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Keep only the configured number of data bits (5..8)
    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] code);
        case (code)
            2'b00:   mask_data = d & 8'h1F;
            2'b01:   mask_data = d & 8'h3F;
            2'b10:   mask_data = d & 8'h7F;
            default: mask_data = d;
        endcase
    endfunction

    // Parity over the configured bits: XOR for even, XNOR for odd
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] code,
                                        input logic odd);
        parity_bit = (^mask_data(d, code)) ^ odd;
    endfunction

    // Index of the last data bit for a data_bits code
    function automatic logic [2:0] last_bit(input logic [1:0] code);
        last_bit = 3'd4 + {1'b0, code};
    endfunction

    // ---------------- baud generator ----------------
    logic [DIV_W-1:0] baud_cnt_r, div_r;
    logic             tick_s;

    assign tick_s = (baud_cnt_r == div_r);

    // Tick counter; the divisor is resampled only on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_r <= DIV_W'(0);
            div_r      <= DIV_W'(0);
        end else if (tick_s) begin
            baud_cnt_r <= DIV_W'(0);
            div_r      <= baud_div;
        end else begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
        end
    end

    // ---------------- transmitter ----------------
    state_t          tx_state_r, tx_state_nxt;
    logic [OS_W-1:0] tx_os_r, tx_os_nxt;
    logic [2:0]      tx_bit_r, tx_bit_nxt;
    logic [7:0]      tx_shift_r, tx_shift_nxt;
    logic [1:0]      tx_code_r, tx_code_nxt;
    logic            tx_pen_r, tx_pen_nxt;
    logic            tx_par_r, tx_par_nxt;
    logic            tx_stop2_r, tx_stop2_nxt;
    logic [7:0]      hold_r, hold_nxt;
    logic            hold_full_r, hold_full_nxt;
    logic            tx_out_r, tx_out_nxt;
    logic            tx_ready_r, tx_ready_nxt;
    logic            tx_busy_r, tx_busy_nxt;

    // TX next-state, holding register handshake and registered output values
    always_comb begin
        tx_state_nxt = tx_state_r;
        tx_os_nxt    = tx_os_r;
        tx_bit_nxt   = tx_bit_r;
        tx_shift_nxt = tx_shift_r;
        tx_code_nxt  = tx_code_r;
        tx_pen_nxt   = tx_pen_r;
        tx_par_nxt   = tx_par_r;
        tx_stop2_nxt = tx_stop2_r;
        hold_nxt     = hold_r;
        hold_full_nxt = hold_full_r;
        tx_out_nxt   = 1'b1;

        if (tx_valid && !hold_full_r) begin
            hold_nxt      = tx_data;
            hold_full_nxt = 1'b1;
        end else begin
            hold_nxt      = hold_r;
        end

        case (tx_state_r)
            ST_IDLE: begin
                if (tick_s && hold_full_r) begin
                    tx_state_nxt  = ST_START;
                    tx_shift_nxt  = mask_data(hold_r, data_bits);
                    tx_code_nxt   = data_bits;
                    tx_pen_nxt    = parity_en;
                    tx_par_nxt    = parity_bit(hold_r, data_bits, parity_odd);
                    tx_stop2_nxt  = stop2;
                    tx_os_nxt     = OS_W'(0);
                    tx_bit_nxt    = 3'd0;
                    hold_full_nxt = 1'b0;
                end else begin
                    tx_state_nxt = ST_IDLE;
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (tick_s && (tx_os_r == OS_LAST)) begin
                    tx_os_nxt = OS_W'(0);
                    case (tx_state_r)
                        ST_START: begin
                            tx_state_nxt = ST_DATA;
                            tx_bit_nxt   = 3'd0;
                        end
                        ST_DATA: begin
                            tx_shift_nxt = {1'b0, tx_shift_r[7:1]};
                            if (tx_bit_r == last_bit(tx_code_r)) begin
                                tx_state_nxt = tx_pen_r ? ST_PARITY : ST_STOP;
                                tx_bit_nxt   = 3'd0;
                            end else begin
                                tx_bit_nxt = tx_bit_r + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            tx_state_nxt = ST_STOP;
                            tx_bit_nxt   = 3'd0;
                        end
                        ST_STOP: begin
                            if (tx_stop2_r && (tx_bit_r == 3'd0)) begin
                                tx_bit_nxt = 3'd1;
                            end else begin
                                tx_state_nxt = ST_IDLE;
                            end
                        end
                        default: tx_state_nxt = ST_IDLE;
                    endcase
                end else if (tick_s) begin
                    tx_os_nxt = tx_os_r + OS_W'(1);
                end else begin
                    tx_os_nxt = tx_os_r;
                end
            end
            default: tx_state_nxt = ST_IDLE;
        endcase

        case (tx_state_nxt)
            ST_START:  tx_out_nxt = 1'b0;
            ST_DATA:   tx_out_nxt = tx_shift_nxt[0];
            ST_PARITY: tx_out_nxt = tx_par_nxt;
            default:   tx_out_nxt = 1'b1;
        endcase

        tx_ready_nxt = !hold_full_nxt;
        tx_busy_nxt  = (tx_state_nxt != ST_IDLE) || hold_full_nxt;
    end

    // TX state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r  <= ST_IDLE;
            tx_os_r     <= OS_W'(0);
            tx_bit_r    <= 3'd0;
            tx_shift_r  <= 8'd0;
            tx_code_r   <= 2'd0;
            tx_pen_r    <= 1'b0;
            tx_par_r    <= 1'b0;
            tx_stop2_r  <= 1'b0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            tx_out_r    <= 1'b1;
            tx_ready_r  <= 1'b1;
            tx_busy_r   <= 1'b0;
        end else begin
            tx_state_r  <= tx_state_nxt;
            tx_os_r     <= tx_os_nxt;
            tx_bit_r    <= tx_bit_nxt;
            tx_shift_r  <= tx_shift_nxt;
            tx_code_r   <= tx_code_nxt;
            tx_pen_r    <= tx_pen_nxt;
            tx_par_r    <= tx_par_nxt;
            tx_stop2_r  <= tx_stop2_nxt;
            hold_r      <= hold_nxt;
            hold_full_r <= hold_full_nxt;
            tx_out_r    <= tx_out_nxt;
            tx_ready_r  <= tx_ready_nxt;
            tx_busy_r   <= tx_busy_nxt;
        end
    end

    assign tx_out   = tx_out_r;
    assign tx_ready = tx_ready_r;
    assign tx_busy  = tx_busy_r;

    // ---------------- receiver ----------------
    logic            rx_s1_r, rx_s2_r, rx_prev_r;
    state_t          rx_state_r, rx_state_nxt;
    logic [OS_W-1:0] rx_os_r, rx_os_nxt;
    logic [2:0]      rx_bit_r, rx_bit_nxt;
    logic [7:0]      rx_word_r, rx_word_nxt;
    logic [1:0]      rx_code_r, rx_code_nxt;
    logic            rx_pen_r, rx_pen_nxt;
    logic            rx_podd_r, rx_podd_nxt;
    logic            rx_perr_r, rx_perr_nxt;
    logic            push_s;
    logic [9:0]      push_entry_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_r   <= 1'b1;
            rx_s2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_s1_r   <= rx_in;
            rx_s2_r   <= rx_s1_r;
            rx_prev_r <= rx_s2_r;
        end
    end

    // RX next-state: start qualification, bit-centre sampling, push on stop
    always_comb begin
        rx_state_nxt = rx_state_r;
        rx_os_nxt    = rx_os_r;
        rx_bit_nxt   = rx_bit_r;
        rx_word_nxt  = rx_word_r;
        rx_code_nxt  = rx_code_r;
        rx_pen_nxt   = rx_pen_r;
        rx_podd_nxt  = rx_podd_r;
        rx_perr_nxt  = rx_perr_r;
        push_s       = 1'b0;
        push_entry_s = {!rx_s2_r, rx_perr_r, rx_word_r};

        case (rx_state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_s2_r) begin
                    rx_state_nxt = ST_START;
                    rx_os_nxt    = OS_W'(0);
                    rx_bit_nxt   = 3'd0;
                    rx_word_nxt  = 8'd0;
                    rx_perr_nxt  = 1'b0;
                    rx_code_nxt  = data_bits;
                    rx_pen_nxt   = parity_en;
                    rx_podd_nxt  = parity_odd;
                end else begin
                    rx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (rx_os_r == OS_HALF)) begin
                    rx_os_nxt = OS_W'(0);
                    if (rx_s2_r) begin
                        rx_state_nxt = ST_IDLE;
                    end else begin
                        rx_state_nxt = ST_DATA;
                    end
                end else if (tick_s) begin
                    rx_os_nxt = rx_os_r + OS_W'(1);
                end else begin
                    rx_os_nxt = rx_os_r;
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (tick_s && (rx_os_r == OS_LAST)) begin
                    rx_os_nxt = OS_W'(0);
                    case (rx_state_r)
                        ST_DATA: begin
                            rx_word_nxt[rx_bit_r] = rx_s2_r;
                            if (rx_bit_r == last_bit(rx_code_r)) begin
                                rx_state_nxt = rx_pen_r ? ST_PARITY : ST_STOP;
                            end else begin
                                rx_bit_nxt = rx_bit_r + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            rx_perr_nxt  = (rx_s2_r != parity_bit(rx_word_r, rx_code_r, rx_podd_r));
                            rx_state_nxt = ST_STOP;
                        end
                        ST_STOP: begin
                            push_s       = 1'b1;
                            rx_state_nxt = ST_IDLE;
                        end
                        default: rx_state_nxt = ST_IDLE;
                    endcase
                end else if (tick_s) begin
                    rx_os_nxt = rx_os_r + OS_W'(1);
                end else begin
                    rx_os_nxt = rx_os_r;
                end
            end
            default: rx_state_nxt = ST_IDLE;
        endcase
    end

    // RX state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_os_r    <= OS_W'(0);
            rx_bit_r   <= 3'd0;
            rx_word_r  <= 8'd0;
            rx_code_r  <= 2'd0;
            rx_pen_r   <= 1'b0;
            rx_podd_r  <= 1'b0;
            rx_perr_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt;
            rx_os_r    <= rx_os_nxt;
            rx_bit_r   <= rx_bit_nxt;
            rx_word_r  <= rx_word_nxt;
            rx_code_r  <= rx_code_nxt;
            rx_pen_r   <= rx_pen_nxt;
            rx_podd_r  <= rx_podd_nxt;
            rx_perr_r  <= rx_perr_nxt;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CNT_W-1:0] count_r, count_nxt;
    logic [9:0]       head_r, head_nxt;
    logic             rx_valid_r, overrun_r, overrun_nxt;
    logic             full_s, pop_s, do_push_s;

    // FIFO control: pop has priority when full, pushes into an empty FIFO win over pops
    always_comb begin
        full_s    = (count_r == CNT_W'(FIFO_DEPTH));
        pop_s     = rx_ready && (count_r != CNT_W'(0));
        do_push_s = push_s && (!full_s || pop_s);
        rd_next_s = rd_ptr_r + PTR_W'(1);
        count_nxt = count_r;
        head_nxt  = head_r;
        overrun_nxt = overrun_r;

        case ({do_push_s, pop_s})
            2'b10:   count_nxt = count_r + CNT_W'(1);
            2'b01:   count_nxt = count_r - CNT_W'(1);
            default: count_nxt = count_r;
        endcase

        if (pop_s) begin
            if (count_r > CNT_W'(1)) begin
                head_nxt = mem_r[rd_next_s];
            end else if (do_push_s) begin
                head_nxt = push_entry_s;
            end else begin
                head_nxt = 10'd0;
            end
        end else if (count_r == CNT_W'(0)) begin
            head_nxt = do_push_s ? push_entry_s : 10'd0;
        end else begin
            head_nxt = head_r;
        end

        if (push_s && full_s && !pop_s) begin
            overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt = 1'b0;
        end else begin
            overrun_nxt = overrun_r;
        end
    end

    // FIFO storage, pointers, occupancy and registered head outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            head_r     <= 10'd0;
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r    <= count_nxt;
            head_r     <= head_nxt;
            rx_valid_r <= (count_nxt != CNT_W'(0));
            overrun_r  <= overrun_nxt;
        end
    end

    assign rx_data       = head_r[7:0];
    assign rx_parity_err = head_r[8];
    assign rx_frame_err  = head_r[9];
    assign rx_valid      = rx_valid_r;
    assign rx_count      = count_r;
    assign rx_overrun    = overrun_r;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: TX waveform, loopback, error flags,
// FIFO overrun, glitch rejection and asynchronous reset mid-frame.
module tb_uart_fifo_core;

    localparam int BIT = 16;  // clk per bit at baud_div=0

    logic        clk, rst;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        parity_en, parity_odd, stop2;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_out, tx_busy;
    logic        rx_line, rx_drv, loop_en;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_frame_err, rx_valid, rx_ready;
    logic [2:0]  rx_count;
    logic        rx_overrun, overrun_clr;

    int checks = 0;
    int errors = 0;

    assign rx_line = loop_en ? tx_out : rx_drv;

    uart_fifo_core dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_line),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_txout(input string tag, input logic val, input int limit);
        for (int i = 0; i < limit && tx_out !== val; i++) @(negedge clk);
        chk(tag, tx_out, val);
    endtask

    task automatic wait_count(input string tag, input logic [2:0] val, input int limit);
        for (int i = 0; i < limit && rx_count !== val; i++) @(negedge clk);
        chk(tag, rx_count, val);
    endtask

    task automatic send_tx(input logic [7:0] d);
        for (int i = 0; i < 2000 && tx_ready !== 1'b1; i++) @(negedge clk);
        chk("send_ready", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input int nbits, input logic has_par,
                               input logic pbit, input logic sbit);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (has_par) begin
            rx_drv = pbit;
            repeat (BIT) @(negedge clk);
        end
        rx_drv = sbit;
        repeat (BIT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        chk({tag, "_valid"}, rx_valid, 1'b1);
        chk({tag, "_data"}, rx_data, d);
        chk({tag, "_perr"}, rx_parity_err, pe);
        chk({tag, "_ferr"}, rx_frame_err, fe);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_bits;
        rst = 1'b1; baud_div = 16'd0; data_bits = 2'b11; parity_en = 1'b0;
        parity_odd = 1'b0; stop2 = 1'b0; tx_data = 8'd0; tx_valid = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_tx_out", tx_out, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_count", rx_count, 3'd0);
        chk("rst_overrun", rx_overrun, 1'b0);
        chk("rst_rx_data", rx_data, 8'd0);
        chk("rst_errs", {rx_frame_err, rx_parity_err}, 2'b00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 8N1 0xA5 waveform, start + LSB-first data + stop
        send_tx(8'hA5);
        wait_txout("t1_start", 1'b0, 50);
        chk("t1_ready_after_start", tx_ready, 1'b1);
        chk("t1_busy", tx_busy, 1'b1);
        exp_bits = 10'b1_1010_0101_0;   // stop, data[7:0], start (LSB sent first)
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_bit%0d", i), tx_out, exp_bits[i]);
            if (i < 9) repeat (BIT) @(negedge clk);
        end
        repeat (BIT / 2 + 1) @(negedge clk);
        chk("t1_busy_done", tx_busy, 1'b0);
        chk("t1_rx_untouched", rx_count, 3'd0);

        // 2: loopback 7E1 two stop bits, 0x35 then 0x4A back-to-back
        data_bits = 2'b10; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        loop_en = 1'b1;
        repeat (2) @(negedge clk);
        send_tx(8'h35);
        wait_txout("t2_start1", 1'b0, 50);
        repeat (BIT * 8 + BIT / 2) @(negedge clk);
        chk("t2_par1", tx_out, 1'b0);
        send_tx(8'h4A);
        wait_txout("t2_stop1", 1'b1, 50);
        wait_txout("t2_start2", 1'b0, 100);
        repeat (BIT * 8 + BIT / 2) @(negedge clk);
        chk("t2_par2", tx_out, 1'b1);
        wait_count("t2_count2", 3'd2, 400);
        pop_check("t2_w1", 8'h35, 1'b0, 1'b0);
        chk("t2_count1", rx_count, 3'd1);
        pop_check("t2_w2", 8'h4A, 1'b0, 1'b0);
        chk("t2_count0", rx_count, 3'd0);
        loop_en = 1'b0;
        repeat (BIT * 3) @(negedge clk);

        // 3: framing error then clean frame, 8N1
        data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b0;
        drive_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        chk("t3_count", rx_count, 3'd1);
        pop_check("t3_bad", 8'h3C, 1'b0, 1'b1);
        drive_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        pop_check("t3_good", 8'h11, 1'b0, 1'b0);

        // 4: overrun with five frames into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) drive_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("t4_count", rx_count, 3'd4);
        chk("t4_overrun", rx_overrun, 1'b1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("t4_pop%0d", i), 8'(i), 1'b0, 1'b0);
        chk("t4_empty", rx_valid, 1'b0);
        chk("t4_empty_data", rx_data, 8'd0);
        chk("t4_sticky", rx_overrun, 1'b1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t4_cleared", rx_overrun, 1'b0);

        // 5: 4-clk glitch rejected, then 5O1 frames with good and bad parity
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_glitch_count", rx_count, 3'd0);
        chk("t5_glitch_ovr", rx_overrun, 1'b0);
        data_bits = 2'b00; parity_en = 1'b1; parity_odd = 1'b1;
        drive_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
        pop_check("t5_ok", 8'h1F, 1'b0, 1'b0);
        drive_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
        pop_check("t5_bad", 8'h1F, 1'b1, 1'b0);

        // 6: reset during data bit 3 at baud_div=3, then an intact frame
        data_bits = 2'b11; parity_en = 1'b0; parity_odd = 1'b0; baud_div = 16'd3;
        send_tx(8'hA5);
        wait_txout("t6_start", 1'b0, 100);
        repeat (BIT * 4 * 4 + BIT * 2) @(negedge clk);
        chk("t6_bit3", tx_out, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx_out", tx_out, 1'b1);
        chk("t6_rst_ready", tx_ready, 1'b1);
        chk("t6_rst_busy", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        loop_en = 1'b1;
        @(negedge clk);
        send_tx(8'h5A);
        wait_count("t6_rx", 3'd1, 1500);
        pop_check("t6_word", 8'h5A, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised successor to the team's fixed-config UART. It adds an internal programmable baud generator, configurable oversampling, a TX holding register with a valid/ready handshake, and an RX FIFO that stores per-word error flags. It also reports sticky overrun. It sits between the chip pins (tx_out/rx_in) and a register or streaming front-end; it replaces the external baud_en strobe.

Parameters:
DIV_W, 16, width of baud_div.
OVERSAMPLE, 16, ticks per bit; even, ≥4.
FIFO_DEPTH, 4, RX FIFO entries; power of 2, ≥2.
CNT_W, $clog2(FIFO_DEPTH+1), width of rx_count.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
baud_div  in  DIV_W  tick period = baud_div+1 clk cycles
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  in  1  1 = parity bit present
parity_odd  in  1  0 = even, 1 = odd
stop2  in  1  0 = one stop bit, 1 = two stop bits (TX); RX always checks one
tx_data  in  8  word to send; bits above data_bits ignored
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
tx_out  out  1  serial out, idle high
tx_busy  out  1  frame in progress or holding register full
rx_in  in  1  serial in, asynchronous
rx_data  out  8  FIFO head; unused upper bits 0
rx_parity_err  out  1  parity error flag of head word
rx_frame_err  out  1  stop-bit error flag of head word
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop head when rx_valid
rx_count  out  CNT_W  FIFO occupancy
rx_overrun  out  1  sticky: word dropped because FIFO was full
overrun_clr  in  1  clears rx_overrun

Behaviour:
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_count=0, rx_overrun=0, rx_data=0, both error outputs 0. All FSMs go to IDLE. Reset mid-frame aborts immediately.
- Baud generator: a counter runs 0..baud_div and pulses tick when it equals baud_div. baud_div=0 gives a tick every cycle. A new baud_div value takes effect when the counter wraps.
- TX handshake:
  - tx_valid&&tx_ready loads the holding register; tx_ready drops next cycle.
  - The TX FSM (IDLE, START, DATA, PARITY, STOP) leaves IDLE on the first tick with the holding register full. It then moves the word to the shift register, latches the config, and sets tx_ready=1 again.
  - Each bit lasts OVERSAMPLE ticks. Data goes LSB first.
  - Parity bit = ^data for even, ~^data for odd, computed over the configured bits only.
  - STOP lasts 1 or 2 bit times. After STOP the FSM returns to IDLE; a full holding register then starts the next frame on the next tick.
  - tx_busy = state!=IDLE || holding full.
- RX front-end: rx_in passes a 2-flop synchroniser (reset to 1).
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: a synchronised high-to-low transition enters START and resets the tick counter. Config is latched here.
  - START: at tick OVERSAMPLE/2-1, the line is sampled. If high, it was a glitch: return to IDLE with no flag. If low, continue; all later samples occur every OVERSAMPLE ticks at bit centre.
  - DATA: shifts in the configured number of bits, LSB first.
  - PARITY (if enabled): a mismatch sets parity_err for this word.
  - STOP: one sample; 0 sets frame_err. Right after the stop sample the word is pushed and the FSM returns to IDLE, so back-to-back frames are accepted.
- RX FIFO entry = {frame_err, parity_err, data[7:0]}.
  - Push while full: the word is dropped, contents are unchanged, and rx_overrun is set.
  - Push and pop in the same cycle while full: pop first, then the push is accepted (count unchanged).
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun_clr clears rx_overrun. If it coincides with a new overrun, set wins.
- Config inputs changing mid-frame affect only the next frame.

Test Plan:
1. Config baud_div=0, OVERSAMPLE=16, 8N1; send 0xA5 → tx_out = 0,1,0,1,0,0,1,0,1,1, each held 16 clk; tx_ready high again after start, tx_busy=0 after stop.
2. Loopback tx_out→rx_in, 7E1 with stop2=1, words 0x35 then 0x4A back-to-back → parity bits 0 and 1; rx_data 0x35, 0x4A in order, no error flags, rx_count 2→0 on pops.
3. Inject 8N1 frame 0x3C with stop bit driven 0 → rx_data=0x3C, rx_frame_err=1; next clean frame 0x11 has both error flags 0.
4. FIFO_DEPTH=4, send 5 frames 0x01..0x05 with rx_ready=0 → rx_count=4, rx_overrun=1, pops return 0x01..0x04; overrun_clr → rx_overrun=0.
5. rx_in low pulse of 4 clk (less than half a bit) → no push, no flags, RX back in IDLE; then a valid 5O1 frame 0x1F → rx_data=0x1F, parity ok.
6. Assert rst mid-TX at data bit 3 with baud_div=3 → tx_out=1, tx_ready=1, tx_busy=0 immediately; next frame after release is sent intact.
